// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state
// encoding and the default operand width.
package serial_cmp_pkg;

  localparam int CMP_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage : serial_cmp_pkg

// File: rtl/cmp_bit_cell.sv
// 1-bit magnitude comparator cell. Purely combinational; exactly one of
// e/g/l is high for any input pair.
module cmp_bit_cell (
  input  logic x_i,
  input  logic y_i,
  output logic e_o,
  output logic g_o,
  output logic l_o
);

  assign e_o = ~(x_i ^ y_i);
  assign g_o = x_i & ~y_i;
  assign l_o = ~x_i & y_i;

endmodule : cmp_bit_cell

// File: rtl/serial_mag_compare_ctrl.sv
// Serial unsigned magnitude comparator. Operands are captured on start and
// walked MSB-first, one bit per clock, through a single comparator cell.
// The first differing bit decides gt/lt immediately; equal operands are
// decided once bit 0 has been examined.
module serial_mag_compare_ctrl
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             eq_o,
  output logic             gt_o,
  output logic             lt_o
);

  // Pointer only ever needs to address WIDTH-1 .. 0.
  localparam int               PTR_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  logic cell_e, cell_g, cell_l;

  // Single comparator cell fed from the captured operands, never the live inputs.
  cmp_bit_cell u_cell (
    .x_i (a_q[ptr_q]),
    .y_i (b_q[ptr_q]),
    .e_o (cell_e),
    .g_o (cell_g),
    .l_o (cell_l)
  );

  // Next-state and datapath update for the IDLE -> COMPARE -> DONE loop.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ptr_d   = ptr_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    case (state_q)
      ST_IDLE: begin
        // Results from the previous compare stay visible until a new start.
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          ptr_d   = PTR_MAX;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (cell_g) begin
          gt_d    = 1'b1;
          state_d = ST_DONE;
        end else if (cell_l) begin
          lt_d    = 1'b1;
          state_d = ST_DONE;
        end else if (cell_e && (ptr_q == '0)) begin
          eq_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          // Bits equal and more remain; pointer is nonzero here so no wrap.
          ptr_d = ptr_q - 1'b1;
        end
      end
      ST_DONE: begin
        // start is deliberately ignored here; no request is queued.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any compare in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ptr_q   <= PTR_MAX;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ptr_q   <= ptr_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  // Outputs are decoded from registers only, so inputs never reach them
  // combinationally.
  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);
  assign eq_o   = eq_q;
  assign gt_o   = gt_q;
  assign lt_o   = lt_q;

endmodule : serial_mag_compare_ctrl

// File: tb/tb_serial_mag_compare_ctrl.sv
// Scoreboard bench for serial_mag_compare_ctrl (WIDTH=8). Stimulus pushes the
// expected {eq,gt,lt} and the cycle the done pulse must appear on; a monitor
// pops and compares on every done pulse.
module tb_serial_mag_compare_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, eq, gt, lt;

  typedef struct {
    logic [2:0] res;   // {eq, gt, lt}
    int         cyc;   // cycle count at which done must be seen
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  serial_mag_compare_ctrl #(.WIDTH(8)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .eq_o    (eq),
    .gt_o    (gt),
    .lt_o    (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: at the negedge after edge En, cyc holds the count of En.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none (cyc %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_result", {29'd0, eq, gt, lt}, {29'd0, e.res});
        chk("done_cycle", cyc, e.cyc);
        chk("done_busy", {31'd0, busy}, 32'd1);
      end
    end
  end

  // One compare: present operands with a one-cycle start pulse, expect done
  // k edges after the accepting edge, optionally disturb the operands after E1.
  task automatic run(input logic [7:0] av, input logic [7:0] bv, input int k,
                     input logic [2:0] res, input bit mutate);
    int   c0;
    int   n;
    exp_t e;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    c0 = cyc;
    start = 1'b0;
    e.res = res; e.cyc = c0 + k;
    exp_q.push_back(e);
    chk("accept_busy", {31'd0, busy}, 32'd1);
    chk("accept_clear", {29'd0, eq, gt, lt}, 32'd0);
    if (mutate) begin
      @(negedge clk);
      a = 8'hC3; b = 8'h00;
    end
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
    chk("busy_fall_cycle", cyc, c0 + k + 1);
    chk("result_hold", {29'd0, eq, gt, lt}, {29'd0, res});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    exp_t e;
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    #3;
    chk("reset_outputs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MSB differs: decided at E1.
    run(8'hA5, 8'h25, 1, 3'b010, 1'b0);
    // Equal operands: decided at E8.
    run(8'h3C, 8'h3C, 8, 3'b100, 1'b0);
    // Differ only at bit 0: lt at E8.
    run(8'h10, 8'h11, 8, 3'b001, 1'b0);
    // Extremes: lt at E1.
    run(8'h00, 8'hFF, 1, 3'b001, 1'b0);
    // Operands change after E1; captured values still compare equal.
    run(8'h3C, 8'h3C, 8, 3'b100, 1'b1);

    // start held high: accepted at E0 and again at E3, nothing in between.
    @(negedge clk);
    a = 8'h80; b = 8'h7F; start = 1'b1;
    @(negedge clk);
    c0 = cyc;
    e.res = 3'b010; e.cyc = c0 + 1; exp_q.push_back(e);
    e.res = 3'b010; e.cyc = c0 + 4; exp_q.push_back(e);
    @(negedge clk);  // after E1: DONE
    chk("held_done_busy", {30'd0, busy, done}, 32'd3);
    @(negedge clk);  // after E2: back to IDLE
    chk("held_idle_gap", {31'd0, busy}, 32'd0);
    @(negedge clk);  // after E3: restarted
    chk("held_restart", {31'd0, busy}, 32'd1);
    @(negedge clk);  // after E4: second done
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("held_stop", {31'd0, busy}, 32'd0);

    // Reset in the middle of an equal-operand compare: no done, all zero.
    @(negedge clk);
    a = 8'h3C; b = 8'h3C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
    @(negedge clk);
    chk("abort_hold", {27'd0, busy, done, eq, gt, lt}, 32'd0);
    rst_n = 1'b1;
    // 0x01 vs 0x00 differs only at bit 0: gt at E8.
    run(8'h01, 8'h00, 8, 3'b010, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_mag_compare_ctrl
